// File: rtl/sram_1r1w_masked_pkg.sv
// Shared types, parameter legality check and lane-merge helper for the
// masked 1R1W SRAM.
package sram_pkg;

  localparam int MAX_WIDTH = 1024;
  localparam int MAX_LANES = 1024;
  localparam int IDX_W     = 10;

  typedef enum logic {CLEAR, READY} init_state_e;

  function automatic bit params_legal(input int depth, input int width,
                                      input int mask_gran, input int rd_latency);
    return (depth >= 2) && (depth <= 65536) &&
           (width >= 1) && (width <= MAX_WIDTH) &&
           (mask_gran >= 1) && ((width % mask_gran) == 0) &&
           (rd_latency >= 1) && (rd_latency <= 2);
  endfunction

  // Takes new_data in lanes whose mask bit is set, old_data elsewhere.
  // Callers zero-extend to MAX_WIDTH and truncate the result back.
  function automatic logic [MAX_WIDTH-1:0] lane_merge(
    input logic [MAX_WIDTH-1:0] old_data,
    input logic [MAX_WIDTH-1:0] new_data,
    input logic [MAX_LANES-1:0] mask,
    input int                   gran
  );
    logic [MAX_WIDTH-1:0] merged;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     lane_idx;
    merged = old_data;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      bit_idx  = IDX_W'(b);
      lane_idx = IDX_W'(b / gran);
      if (mask[lane_idx]) merged[bit_idx] = new_data[bit_idx];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_1r1w_masked_if.sv
// Read/write port bundle of the masked 1R1W SRAM.
interface sram_1r1w_masked_if #(
  parameter int AW    = 9,
  parameter int WIDTH = 64,
  parameter int NL    = 8
);
  logic             R0_en;
  logic [AW-1:0]    R0_addr;
  logic [WIDTH-1:0] R0_data;
  logic             R0_valid;
  logic             W0_en;
  logic [AW-1:0]    W0_addr;
  logic [WIDTH-1:0] W0_data;
  logic [NL-1:0]    W0_mask;
  logic             init_busy;

  modport master (
    output R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
    input  R0_data, R0_valid, init_busy
  );

  modport slave (
    input  R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
    output R0_data, R0_valid, init_busy
  );
endinterface

// File: rtl/sram_1r1w_masked_init_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then hands the
// array over to the ports.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          init_busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  init_state_e   state_reg;
  logic [AW-1:0] cnt_reg;
  logic          busy_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_reg   <= '0;
      busy_reg  <= CLEAR_ON_RESET;
    end else if (state_reg == CLEAR) begin
      cnt_reg <= cnt_reg + AW'(1);
      if (cnt_reg == LAST_ADDR) begin
        state_reg <= READY;
        busy_reg  <= 1'b0;
      end
    end
  end

  assign init_busy = busy_reg;
  assign clr_addr  = cnt_reg;
  assign clr_we    = busy_reg;

endmodule

// File: rtl/sram_1r1w_masked.sv
// Masked 1R1W SRAM: lane-masked writes, pipelined registered reads with
// optional same-address forwarding, and zero-fill after reset.
module sram_1r1w_masked
  import sram_pkg::*;
#(
  parameter int  DEPTH          = 512,
  parameter int  WIDTH          = 64,
  parameter int  MASK_GRAN      = 8,
  parameter int  RD_LATENCY     = 1,
  parameter bit  BYPASS         = 1'b1,
  parameter bit  CLEAR_ON_RESET = 1'b1,
  localparam int AW             = $clog2(DEPTH),
  localparam int NL             = WIDTH / MASK_GRAN
) (
  input logic               clock,
  input logic               reset,
  sram_1r1w_masked_if.slave bus
);

  generate
    if (!params_legal(DEPTH, WIDTH, MASK_GRAN, RD_LATENCY)) begin : g_param_check
      $error("sram_1r1w_masked: illegal DEPTH/WIDTH/MASK_GRAN/RD_LATENCY");
    end
  endgenerate

  logic          init_busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  sram_init_ctrl #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_ctrl (
    .clock     (clock),
    .reset     (reset),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  logic [WIDTH-1:0] mem [DEPTH];

  logic rd_ok;
  logic wr_ok;
  logic rd_fire;
  logic wr_fire;

  assign rd_ok   = int'(bus.R0_addr) < DEPTH;
  assign wr_ok   = int'(bus.W0_addr) < DEPTH;
  assign rd_fire = bus.R0_en & ~init_busy;
  assign wr_fire = bus.W0_en & ~init_busy & ~reset & wr_ok;

  // The clear sequencer and the write port share one lane-enabled write
  // path so the array keeps a single byte-write port.
  logic [NL-1:0]    lane_we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign waddr = clr_we ? clr_addr : bus.W0_addr;
  assign wdata = clr_we ? '0 : bus.W0_data;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane_we
    assign lane_we[gi] = clr_we | (wr_fire & bus.W0_mask[gi]);
  end

  always_ff @(posedge clock) begin
    for (int li = 0; li < NL; li++) begin
      if (lane_we[li]) begin
        mem[waddr][li*MASK_GRAN +: MASK_GRAN] <= wdata[li*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  // Stage A: registered array read plus the colliding write, merged after
  // the register so the array read stays a plain synchronous read.
  logic             valid_a_reg;
  logic             byp_hit_a_reg;
  logic [WIDTH-1:0] rd_a_reg;
  logic [WIDTH-1:0] byp_data_a_reg;
  logic [NL-1:0]    byp_mask_a_reg;
  logic [WIDTH-1:0] resp_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_a_reg <= 1'b0;
    end else begin
      valid_a_reg <= rd_fire;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_fire) begin
      rd_a_reg       <= rd_ok ? mem[bus.R0_addr] : '0;
      byp_hit_a_reg  <= BYPASS && wr_fire && (bus.W0_addr == bus.R0_addr);
      byp_data_a_reg <= bus.W0_data;
      byp_mask_a_reg <= bus.W0_mask;
    end
  end

  always_comb begin
    resp_a = rd_a_reg;
    if (byp_hit_a_reg) begin
      resp_a = WIDTH'(lane_merge(MAX_WIDTH'(rd_a_reg), MAX_WIDTH'(byp_data_a_reg),
                                 MAX_LANES'(byp_mask_a_reg), MASK_GRAN));
    end
  end

  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic             valid_b_reg;
      logic [WIDTH-1:0] data_b_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_b_reg <= 1'b0;
        end else begin
          valid_b_reg <= valid_a_reg;
        end
      end

      always_ff @(posedge clock) begin
        if (valid_a_reg) data_b_reg <= resp_a;
      end

      assign out_valid = valid_b_reg;
      assign out_data  = data_b_reg;
    end else begin : g_lat1
      assign out_valid = valid_a_reg;
      assign out_data  = resp_a;
    end
  endgenerate

  // Output register holds the last response while R0_valid is low.
  logic             r0_valid_reg;
  logic [WIDTH-1:0] r0_data_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      r0_valid_reg <= 1'b0;
      r0_data_reg  <= '0;
    end else begin
      r0_valid_reg <= out_valid;
      if (out_valid) r0_data_reg <= out_data;
    end
  end

  assign bus.R0_valid  = r0_valid_reg;
  assign bus.R0_data   = r0_data_reg;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Directed bench: dut_a (DEPTH 512, latency 1, bypass) and dut_b (DEPTH 300,
// latency 2, no bypass) share one stimulus stream.
module tb_sram_1r1w_masked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0_en;
  logic [8:0]  r0_addr;
  logic        w0_en;
  logic [8:0]  w0_addr;
  logic [63:0] w0_data;
  logic [7:0]  w0_mask;

  sram_1r1w_masked_if #(.AW(9), .WIDTH(64), .NL(8)) ifa ();
  sram_1r1w_masked_if #(.AW(9), .WIDTH(64), .NL(8)) ifb ();

  assign ifa.R0_en   = r0_en;
  assign ifa.R0_addr = r0_addr;
  assign ifa.W0_en   = w0_en;
  assign ifa.W0_addr = w0_addr;
  assign ifa.W0_data = w0_data;
  assign ifa.W0_mask = w0_mask;
  assign ifb.R0_en   = r0_en;
  assign ifb.R0_addr = r0_addr;
  assign ifb.W0_en   = w0_en;
  assign ifb.W0_addr = w0_addr;
  assign ifb.W0_data = w0_data;
  assign ifb.W0_mask = w0_mask;

  sram_1r1w_masked #(
    .DEPTH(512), .WIDTH(64), .MASK_GRAN(8), .RD_LATENCY(1),
    .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (ifa)
  );

  sram_1r1w_masked #(
    .DEPTH(300), .WIDTH(64), .MASK_GRAN(8), .RD_LATENCY(2),
    .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)
  ) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ifb)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } resp_t;

  resp_t qa[$];
  resp_t qb[$];

  always @(negedge clk) begin
    if (ifa.R0_valid) qa.push_back('{cyc, ifa.R0_data});
    if (ifb.R0_valid) qb.push_back('{cyc, ifb.R0_data});
  end

  typedef struct {
    logic        we;
    logic [8:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        re;
    logic [8:0]  ra;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  int   acc[NV];

  int busy_a, busy_b, val_a, val_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic lookup(input bit which, input int c, output logic [63:0] d);
    d = 'x;
    if (which == 1'b0) begin
      foreach (qa[i]) if (qa[i].cyc == c) d = qa[i].data;
    end else begin
      foreach (qb[i]) if (qb[i].cyc == c) d = qb[i].data;
    end
  endtask

  task automatic idle();
    r0_en   = 1'b0;
    r0_addr = '0;
    w0_en   = 1'b0;
    w0_addr = '0;
    w0_data = '0;
    w0_mask = '0;
  endtask

  // Counts busy and valid samples over n_cycles negedges, issuing reads of
  // address 5 during the first rd_cycles of them.
  task automatic run_clear(input int n_cycles, input int rd_cycles);
    busy_a = 0; busy_b = 0; val_a = 0; val_b = 0;
    for (int n = 0; n < n_cycles; n++) begin
      r0_en   = (n < rd_cycles);
      r0_addr = 9'd5;
      if (ifa.init_busy) busy_a++;
      if (ifb.init_busy) busy_b++;
      if (ifa.R0_valid) val_a++;
      if (ifb.R0_valid) val_b++;
      @(negedge clk);
    end
    r0_en = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    int          nreads;
    int          na, nb, c;

    idle();
    rst = 1'b1;

    vecs[0]  = '{1'b1, 9'd5,   64'h1122334455667788, 8'hFF, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[1]  = '{1'b1, 9'd5,   64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[2]  = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd5,   64'h11223344FFFFFFFF, 64'h11223344FFFFFFFF};
    vecs[3]  = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd511, 64'h0, 64'h0};
    vecs[4]  = '{1'b1, 9'd7,   64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b1, 9'd7,   64'hAAAAAAAAAAAAAAAA, 64'h0};
    vecs[5]  = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd7,   64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA};
    vecs[6]  = '{1'b1, 9'd300, 64'hDEADBEEF00C0FFEE, 8'hFF, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[7]  = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd300, 64'hDEADBEEF00C0FFEE, 64'h0};
    vecs[8]  = '{1'b1, 9'd1,   64'h0123456789ABCDEF, 8'hFF, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[9]  = '{1'b1, 9'd2,   64'h0F1E2D3C4B5A6978, 8'hFF, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[10] = '{1'b1, 9'd3,   64'hCAFEBABEDEADBEEF, 8'h81, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[11] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd1,   64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[12] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd2,   64'h0F1E2D3C4B5A6978, 64'h0F1E2D3C4B5A6978};
    vecs[13] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd3,   64'hCA000000000000EF, 64'hCA000000000000EF};
    vecs[14] = '{1'b1, 9'd1,   64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 9'd1,   64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[15] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd1,   64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[16] = '{1'b1, 9'd2,   64'hFFFFFFFFFFFFFFFF, 8'hF0, 1'b1, 9'd2,   64'hFFFFFFFF4B5A6978, 64'h0F1E2D3C4B5A6978};
    vecs[17] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd2,   64'hFFFFFFFF4B5A6978, 64'hFFFFFFFF4B5A6978};
    vecs[18] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd3,   64'hCA000000000000EF, 64'hCA000000000000EF};
    vecs[19] = '{1'b1, 9'd3,   64'h5555555555555555, 8'hFF, 1'b0, 9'd0,   64'h0, 64'h0};
    vecs[20] = '{1'b0, 9'd0,   64'h0,                8'h00, 1'b1, 9'd3,   64'h5555555555555555, 64'h5555555555555555};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_a", 64'(ifa.R0_valid), 64'd0);
    check("rst_data_a",  ifa.R0_data,       64'd0);
    check("rst_busy_a",  64'(ifa.init_busy), 64'd1);
    check("rst_valid_b", 64'(ifb.R0_valid), 64'd0);
    check("rst_data_b",  ifb.R0_data,       64'd0);
    check("rst_busy_b",  64'(ifb.init_busy), 64'd1);

    // Full clear with reads attempted during the first 50 busy cycles
    rst = 1'b0;
    run_clear(1000, 50);
    check("clear_busy_a", 64'(busy_a), 64'd512);
    check("clear_busy_b", 64'(busy_b), 64'd300);
    check("clear_valid_a", 64'(val_a), 64'd0);
    check("clear_valid_b", 64'(val_b), 64'd0);

    // Table-driven traffic, one vector per cycle
    for (int i = 0; i < NV; i++) begin
      w0_en   = vecs[i].we;
      w0_addr = vecs[i].wa;
      w0_data = vecs[i].wd;
      w0_mask = vecs[i].wm;
      r0_en   = vecs[i].re;
      r0_addr = vecs[i].ra;
      @(posedge clk);
      #1 acc[i] = cyc;
      @(negedge clk);
    end
    idle();
    repeat (6) @(negedge clk);

    nreads = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].re) begin
        nreads++;
        lookup(1'b0, acc[i] + 1, d);
        check($sformatf("vec%0d_a", i), d, vecs[i].exp_a);
        lookup(1'b1, acc[i] + 2, d);
        check($sformatf("vec%0d_b", i), d, vecs[i].exp_b);
      end
    end
    check("resp_count_a", 64'(qa.size()), 64'(nreads));
    check("resp_count_b", 64'(qb.size()), 64'(nreads));

    // Read in flight when reset asserts must never complete
    na = qa.size();
    nb = qb.size();
    r0_en   = 1'b1;
    r0_addr = 9'd5;
    @(negedge clk);
    r0_en = 1'b0;
    rst   = 1'b1;
    repeat (4) @(negedge clk);
    check("pending_a", 64'(qa.size() - na), 64'd0);
    check("pending_b", 64'(qb.size() - nb), 64'd0);
    check("rst2_data_a", ifa.R0_data, 64'd0);
    check("rst2_data_b", ifb.R0_data, 64'd0);
    check("rst2_busy_a", 64'(ifa.init_busy), 64'd1);

    // Reset 100 cycles into the clear restarts it from entry 0
    rst = 1'b0;
    run_clear(100, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_clear(1000, 0);
    check("reclear_busy_a", 64'(busy_a), 64'd512);
    check("reclear_busy_b", 64'(busy_b), 64'd300);

    // Entry 5 held non-zero data before the re-clear
    r0_en   = 1'b1;
    r0_addr = 9'd5;
    @(posedge clk);
    #1 c = cyc;
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    lookup(1'b0, c + 1, d);
    check("reclear_rd5_a", d, 64'd0);
    lookup(1'b1, c + 2, d);
    check("reclear_rd5_b", d, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_masked.md
SRAM_1R1W_MASKED -- requirements
Module: sram_1r1w_masked

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 512, giving the number of entries (2..65536, not required to be a power of two).
REQ-002 The block SHALL have a parameter WIDTH, default 64, giving the data bits per entry.
REQ-003 The block SHALL have a parameter MASK_GRAN, default 8, giving the bits per write-mask lane; WIDTH SHALL be a multiple of MASK_GRAN.
REQ-004 The block SHALL have a parameter RD_LATENCY, default 1, giving cycles from read request to data; legal values are 1 and 2.
REQ-005 The block SHALL have a parameter BYPASS, default 1, selecting write-to-read forwarding on a same-address collision.
REQ-006 The block SHALL have a parameter CLEAR_ON_RESET, default 1, enabling zero-fill of the array after reset.
REQ-007 AW SHALL be defined as clog2(DEPTH) and NL SHALL be defined as WIDTH/MASK_GRAN.
REQ-008 The block SHALL have port clock  in  1  as its single clock; all state is updated on its rising edge.
REQ-009 The block SHALL have port reset  in  1  as a synchronous, active-high reset.
REQ-010 The block SHALL have port R0_en  in  1  as the read request.
REQ-011 The block SHALL have port R0_addr  in  AW  as the read address.
REQ-012 The block SHALL have port R0_data  out  WIDTH  as the read data.
REQ-013 The block SHALL have port R0_valid  out  1  marking the cycle in which R0_data carries a response.
REQ-014 The block SHALL have port W0_en  in  1  as the write request.
REQ-015 The block SHALL have port W0_addr  in  AW  as the write address.
REQ-016 The block SHALL have port W0_data  in  WIDTH  as the write data.
REQ-017 The block SHALL have port W0_mask  in  NL  as the per-lane write enable, bit i covering data bits [i*MASK_GRAN +: MASK_GRAN].
REQ-018 The block SHALL have port init_busy  out  1  indicating that the post-reset clear is in progress.

Function
REQ-019 The block SHALL implement a two-state control FSM: CLEAR and READY.
REQ-020 When reset is high with CLEAR_ON_RESET=1, the FSM SHALL enter CLEAR with the clear counter at 0; with CLEAR_ON_RESET=0 it SHALL enter READY.
REQ-021 In CLEAR, the block SHALL write all-zero to entry [counter] and increment the counter by 1 on each cycle.
REQ-022 The FSM SHALL move from CLEAR to READY after writing entry DEPTH-1, so init_busy is high for exactly DEPTH cycles after reset deasserts.
REQ-023 In CLEAR, R0_en and W0_en SHALL be ignored: no array update from the ports and no R0_valid.
REQ-024 In READY, a write with W0_en=1 SHALL update only the lanes whose W0_mask bit is 1; an all-zero mask SHALL leave the entry unchanged.
REQ-025 A read accepted with R0_en=1 at edge k SHALL drive R0_data with R0_valid=1 from edge k+RD_LATENCY for exactly one cycle.
REQ-026 The read path SHALL accept back-to-back reads on every cycle, giving one response per cycle.
REQ-027 When R0_valid=0, R0_data SHALL hold its last driven value and SHALL never be X.
REQ-028 On a same-cycle read and write to the same address with BYPASS=1, the response SHALL be the merged entry: new data in masked lanes and old data in the other lanes.
REQ-029 On a same-cycle read and write to the same address with BYPASS=0, the response SHALL be the pre-write contents.
REQ-030 With RD_LATENCY=2, the response SHALL still reflect array contents as of the read's acceptance edge; a write in the intervening cycle SHALL NOT alter it.
REQ-031 A write with address >= DEPTH SHALL be dropped.
REQ-032 A read with address >= DEPTH SHALL return all-zero with R0_valid asserted normally.

Reset
REQ-033 When reset is high, R0_valid SHALL be 0, R0_data SHALL be 0, and init_busy SHALL be CLEAR_ON_RESET.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight reads, with no R0_valid for them.
REQ-035 Reset asserted mid-clear SHALL restart the clear from entry 0.
REQ-036 Array contents SHALL NOT be reset directly; they are defined only through the clear or through writes.

Structure
REQ-037 Package sram_pkg SHALL hold the parameter legality checks, the FSM state enum (CLEAR, READY) and a lane-merge function (old, new, mask).
REQ-038 The clear counter and FSM SHALL be a sub-module, sram_init_ctrl, providing init_busy, clear address and clear write enable.
REQ-039 The storage array SHALL be a single behavioural register array so that memory-compiler substitution remains possible.
REQ-040 Illegal parameter combinations (RD_LATENCY outside 1..2, or WIDTH not a multiple of MASK_GRAN) SHALL cause an elaboration-time error.

Verification
REQ-041 Clear scenario (DEPTH=512): release reset -> init_busy high for exactly 512 cycles; then a read of address 0x1FF returns 0.
REQ-042 Masked write: write 0x1122334455667788 to address 5, then write 0xFFFFFFFFFFFFFFFF with mask 0x0F -> a read of address 5 returns 0x11223344FFFFFFFF.
REQ-043 Collision: entry 7 = 0, then a same-cycle write of 0xAA..AA (mask 0xFF) and read of address 7 -> returns 0xAA..AA with BYPASS=1 and 0 with BYPASS=0.
REQ-044 Pipeline (RD_LATENCY=2): read addresses 1, 2, 3 on consecutive cycles -> R0_valid high on 3 consecutive cycles starting 2 cycles later, with data in order.
REQ-045 Reset mid-clear at cycle 100, released -> init_busy high for a further 512 cycles; a read pending at reset never produces R0_valid.
REQ-046 DEPTH=300: a write to address 300 is dropped and a read of address 300 returns 0 with R0_valid=1.
